// File: rtl/div_bcd_conv_if.sv
// -----------------------------------------------------------------------------
// div_bcd_conv_if
// Handshake/data bundle between the divider result and the BCD converter.
//   start      : convert request (driven by the divider's done_tick)
//   quo, rmd   : binary quotient / remainder, W bits
//   ready      : converter is idle and will accept start
//   done_tick  : one-cycle pulse when quo_bcd / rmd_bcd update
//   quo_bcd    : packed 3-digit BCD of quo ([11:8] hundreds .. [3:0] ones)
//   rmd_bcd    : packed 3-digit BCD of rmd, same packing
// master = producer side (divider / display path), slave = converter.
// -----------------------------------------------------------------------------
interface div_bcd_conv_if #(
    parameter int W = 8
);
    logic          start;
    logic [W-1:0]  quo;
    logic [W-1:0]  rmd;
    logic          ready;
    logic          done_tick;
    logic [11:0]   quo_bcd;
    logic [11:0]   rmd_bcd;

    modport master (
        output start, quo, rmd,
        input  ready, done_tick, quo_bcd, rmd_bcd
    );

    modport slave (
        input  start, quo, rmd,
        output ready, done_tick, quo_bcd, rmd_bcd
    );
endinterface

// File: rtl/div_bcd_conv.sv
// -----------------------------------------------------------------------------
// div_bcd_conv
// Converts the divider's quotient and remainder to 3-digit packed BCD in
// parallel using iterative double-dabble (adjust-by-3, then shift), one
// binary bit per clock. Published results only change on done_tick.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : div_bcd_conv_if.slave (start/quo/rmd in, ready/done_tick/BCD out)
//
// Parameter W: binary operand width, 1..9 (result must fit in 999).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready=1, waiting for start; operands captured on accept
// OP    | one adjust+shift step per cycle, W cycles total
// DONE  | copy working BCD to outputs, pulse done_tick, back to IDLE
// -----------------------------------------------------------------------------
module div_bcd_conv #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    div_bcd_conv_if.slave  bus
);

    if (W < 1 || W > 9) begin : g_bad_width
        $error("div_bcd_conv: W must be in 1..9");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  bin_q;
    logic [W-1:0]  bin_r;
    logic [11:0]   bcd_q;
    logic [11:0]   bcd_r;
    logic [3:0]    cnt;
    logic [11:0]   quo_bcd_reg;
    logic [11:0]   rmd_bcd_reg;
    logic          done_tick_reg;

    logic          load;
    logic          shift;
    logic          publish;
    logic [11:0]   adj_q;
    logic [11:0]   adj_r;

    // Each digit is adjusted on its own; a digit >= 5 becomes >= 8 and
    // carries into the next digit through the following shift, not here.
    function automatic logic [11:0] adj3(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (v[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign adj_q = adj3(bcd_q);
    assign adj_r = adj3(bcd_r);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        publish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = OP;
                end
            end
            OP: begin
                shift = 1'b1;
                // terminal count: this is the last bit
                if (cnt == 4'd1)
                    state_nxt = DONE;
            end
            DONE: begin
                publish   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q         <= '0;
            bin_r         <= '0;
            bcd_q         <= '0;
            bcd_r         <= '0;
            cnt           <= '0;
            quo_bcd_reg   <= '0;
            rmd_bcd_reg   <= '0;
            done_tick_reg <= 1'b0;
        end else begin
            done_tick_reg <= publish;
            if (load) begin
                bin_q <= bus.quo;
                bin_r <= bus.rmd;
                bcd_q <= '0;
                bcd_r <= '0;
                cnt   <= 4'(W);
            end else if (shift) begin
                // {bcd, bin} << 1 after adjust: binary MSB enters BCD bit 0
                bcd_q <= {adj_q[10:0], bin_q[W-1]};
                bcd_r <= {adj_r[10:0], bin_r[W-1]};
                bin_q <= bin_q << 1;
                bin_r <= bin_r << 1;
                cnt   <= cnt - 4'd1;
            end
            if (publish) begin
                quo_bcd_reg <= bcd_q;
                rmd_bcd_reg <= bcd_r;
            end
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.done_tick = done_tick_reg;
    assign bus.quo_bcd   = quo_bcd_reg;
    assign bus.rmd_bcd   = rmd_bcd_reg;

endmodule

// File: tb/tb_div_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_div_bcd_conv
// Directed bench for div_bcd_conv (W=8): a table of quo/rmd vectors with
// hand-computed BCD results, plus sequences for reset, busy start, continuous
// start and reset during a conversion.
// -----------------------------------------------------------------------------
module tb_div_bcd_conv;

    localparam int W   = 8;
    localparam int LAT = W + 1;
    localparam int PER = W + 2;

    logic clk;
    logic reset;

    div_bcd_conv_if #(.W(W)) bus ();

    div_bcd_conv #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0]  quo;
        logic [7:0]  rmd;
        logic [11:0] exp_q;
        logic [11:0] exp_r;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Called #1 after a rising edge with the DUT idle; returns the same way.
    task automatic run_conv(input logic [7:0] q, input logic [7:0] r,
                            input logic [11:0] eq, input logic [11:0] er,
                            input string tag);
        int  lat;
        int  rlow;
        bit  seen;
        bus.start = 1'b1;
        bus.quo   = q;
        bus.rmd   = r;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.quo   = ~q;
        bus.rmd   = r ^ 8'h5A;
        rlow = bus.ready ? 0 : 1;
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus.done_tick) begin
                seen = 1'b1;
                lat  = c;
            end else if (!bus.ready) begin
                rlow++;
            end
        end
        check({tag, "_latency"}, 16'(lat), 16'(LAT));
        check({tag, "_quo_bcd"}, 16'(bus.quo_bcd), 16'(eq));
        check({tag, "_rmd_bcd"}, 16'(bus.rmd_bcd), 16'(er));
        check({tag, "_ready_low_cycles"}, 16'(rlow), 16'(LAT));
        check({tag, "_ready_at_done"}, 16'(bus.ready), 16'd1);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 16'(bus.done_tick), 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int first_lat;
        int ndone;
        int t[3];

        vecs[0]  = '{8'd4,   8'd2,   12'h004, 12'h002};
        vecs[1]  = '{8'd10,  8'd2,   12'h010, 12'h002};
        vecs[2]  = '{8'd255, 8'd0,   12'h255, 12'h000};
        vecs[3]  = '{8'd6,   8'd1,   12'h006, 12'h001};
        vecs[4]  = '{8'd0,   8'd0,   12'h000, 12'h000};
        vecs[5]  = '{8'd9,   8'd10,  12'h009, 12'h010};
        vecs[6]  = '{8'd59,  8'd95,  12'h059, 12'h095};
        vecs[7]  = '{8'd1,   8'd1,   12'h001, 12'h001};
        vecs[8]  = '{8'd128, 8'd127, 12'h128, 12'h127};
        vecs[9]  = '{8'd100, 8'd99,  12'h100, 12'h099};
        vecs[10] = '{8'd0,   8'd255, 12'h000, 12'h255};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.quo   = '0;
        bus.rmd   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",     16'(bus.ready),     16'd1);
        check("rst_done_tick", 16'(bus.done_tick), 16'd0);
        check("rst_quo_bcd",   16'(bus.quo_bcd),   16'h000);
        check("rst_rmd_bcd",   16'(bus.rmd_bcd),   16'h000);

        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.done_tick || !bus.ready) dones++;
        end
        check("idle_no_activity", 16'(dones),       16'd0);
        check("idle_quo_bcd",     16'(bus.quo_bcd), 16'h000);
        check("idle_rmd_bcd",     16'(bus.rmd_bcd), 16'h000);

        for (int i = 0; i < 11; i++)
            run_conv(vecs[i].quo, vecs[i].rmd, vecs[i].exp_q, vecs[i].exp_r,
                     $sformatf("vec%0d", i));

        // start pulse during OP cycle 3 must be dropped
        bus.start = 1'b1;
        bus.quo   = 8'd99;
        bus.rmd   = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones     = 0;
        first_lat = 0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin
                bus.start = 1'b1;
                bus.quo   = 8'd1;
                bus.rmd   = 8'd1;
            end
            if (c == 4) bus.start = 1'b0;
            if (bus.done_tick) begin
                dones++;
                if (first_lat == 0) first_lat = c;
            end
        end
        check("busy_done_count", 16'(dones),       16'd1);
        check("busy_latency",    16'(first_lat),   16'(LAT));
        check("busy_quo_bcd",    16'(bus.quo_bcd), 16'h099);
        check("busy_rmd_bcd",    16'(bus.rmd_bcd), 16'h007);

        // start held high: one conversion per W+2 cycles
        bus.start = 1'b1;
        bus.quo   = 8'd200;
        bus.rmd   = 8'd50;
        ndone = 0;
        t = '{0, 0, 0};
        for (int c = 1; c <= 60 && ndone < 3; c++) begin
            @(posedge clk); #1;
            if (bus.done_tick) begin
                t[ndone] = c;
                ndone++;
                check($sformatf("cont%0d_quo_bcd", ndone), 16'(bus.quo_bcd), 16'h200);
                check($sformatf("cont%0d_rmd_bcd", ndone), 16'(bus.rmd_bcd), 16'h050);
                if (ndone == 3) bus.start = 1'b0;
            end
        end
        check("cont_done_count", 16'(ndone),       16'd3);
        check("cont_first_done", 16'(t[0]),        16'(LAT + 1));
        check("cont_period_1",   16'(t[1] - t[0]), 16'(PER));
        check("cont_period_2",   16'(t[2] - t[1]), 16'(PER));

        // reset on OP cycle 5 aborts the conversion
        bus.start = 1'b1;
        bus.quo   = 8'd123;
        bus.rmd   = 8'd45;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ready",     16'(bus.ready),     16'd1);
        check("abort_done_tick", 16'(bus.done_tick), 16'd0);
        check("abort_quo_bcd",   16'(bus.quo_bcd),   16'h000);
        check("abort_rmd_bcd",   16'(bus.rmd_bcd),   16'h000);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.done_tick) dones++;
        end
        check("abort_no_done", 16'(dones), 16'd0);

        run_conv(8'd123, 8'd45, 12'h123, 12'h045, "after_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
